// File: rtl/conv_host_pkg.sv
// Shared types and defaults for the convolution-engine host interface.
package conv_host_pkg;

    localparam int DW_IN         = 8;
    localparam int DW_OUT        = 16;
    localparam int CW            = 11;
    localparam int KMAX_SQ_DEF   = 64;
    localparam int IMG_DEPTH_DEF = 1024;

    typedef enum logic [3:0] {
        IDLE, COLLECT, KPULSE, KLOAD, XPULSE, XLOAD, START, WAIT_DONE, CAPTURE, DRAIN
    } state_t;

    function automatic logic [19:0] sq10(input logic [9:0] v);
        return {10'd0, v} * {10'd0, v};
    endfunction

endpackage

// File: rtl/conv_host_fifo.sv
// Synchronous first-word-fall-through FIFO for the result path.
module conv_host_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          wr_ok, rd_ok;

    assign wr_ok   = wr_en && (count != FULL);
    assign rd_ok   = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);

    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/conv_host_if.sv
// Host initiator: stages one job, bursts it into the engine, streams results out.
// Optional CONV_HOST_PERF_EN adds perf_cycles (eng_start..eng_done cycle count).
module conv_host_if
    import conv_host_pkg::*;
#(
    parameter int KMAX_SQ   = KMAX_SQ_DEF,
    parameter int IMG_DEPTH = IMG_DEPTH_DEF,
    parameter int RD_LAT    = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     job_start,
    input  logic [9:0]               cfg_n,
    input  logic [2:0]               cfg_k,
    output logic                     busy,
    output logic                     job_err,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DW_IN-1:0]  s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DW_OUT-1:0] m_data,
    output logic                     m_last,
    output logic [9:0]               eng_X,
    output logic [2:0]               eng_H,
    output logic                     eng_load_h,
    output logic                     eng_load_x,
    output logic                     eng_start,
    output logic [DW_IN-1:0]         eng_data_in,
    input  logic                     eng_done,
    input  logic [DW_OUT-1:0]        eng_data_out,
    output logic                     eng_reset
`ifdef CONV_HOST_PERF_EN
    ,
    output logic [31:0]              perf_cycles
`endif
);
    localparam int KAW = $clog2(KMAX_SQ);
    localparam int IAW = $clog2(IMG_DEPTH);
    localparam logic [3:0] LAT0 = 4'(RD_LAT - 1);

    state_t          state;
    logic [CW-1:0]   kk_r, nn_r, mm_r, in_cnt, ld_cnt, cap_cnt, out_cnt, iaddr;
    logic [3:0]      lat_cnt;
    logic [DW_IN-1:0] kbuf [KMAX_SQ];
    logic [DW_IN-1:0] ibuf [IMG_DEPTH];
    logic [19:0]     k_sq, n_sq;
    logic [9:0]      m_side;
    logic            cfg_bad, s_hs, m_hs, kwr, iwr, fifo_wr, fifo_empty;
    logic [DW_OUT-1:0] fifo_q;

    assign k_sq    = sq10({7'd0, cfg_k});
    assign n_sq    = sq10(cfg_n);
    assign m_side  = cfg_n - {7'd0, cfg_k} + 10'd1;
    assign cfg_bad = (cfg_k == 3'd0) || ({7'd0, cfg_k} > cfg_n) ||
                     (k_sq > 20'(KMAX_SQ)) || (n_sq > 20'(IMG_DEPTH));

    assign s_hs    = s_valid && s_ready;
    assign kwr     = s_hs && (in_cnt < kk_r);
    assign iwr     = s_hs && !(in_cnt < kk_r);
    assign iaddr   = in_cnt - kk_r;
    assign fifo_wr = (state == CAPTURE) && (lat_cnt == '0);
    assign m_valid = !fifo_empty;
    assign m_hs    = m_valid && m_ready;
    assign m_data  = m_valid ? fifo_q : '0;
    assign m_last  = m_valid && (out_cnt == mm_r - 11'd1);

    always_ff @(posedge clk) begin
        if (kwr) kbuf[in_cnt[KAW-1:0]] <= s_data;
        if (iwr) ibuf[iaddr[IAW-1:0]]  <= s_data;
    end

    // Buffer read register is eng_data_in itself: word 0 is fetched during the pulse cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            job_err     <= 1'b0;
            s_ready     <= 1'b0;
            eng_X       <= '0;
            eng_H       <= '0;
            eng_load_h  <= 1'b0;
            eng_load_x  <= 1'b0;
            eng_start   <= 1'b0;
            eng_data_in <= '0;
            eng_reset   <= 1'b1;
            kk_r        <= '0;
            nn_r        <= '0;
            mm_r        <= '0;
            in_cnt      <= '0;
            ld_cnt      <= '0;
            cap_cnt     <= '0;
            out_cnt     <= '0;
            lat_cnt     <= '0;
        end else begin
            eng_reset  <= 1'b0;
            job_err    <= 1'b0;
            eng_load_h <= 1'b0;
            eng_load_x <= 1'b0;
            eng_start  <= 1'b0;
            if (m_hs) out_cnt <= out_cnt + 11'd1;
            case (state)
                IDLE: if (job_start) begin
                    if (cfg_bad) job_err <= 1'b1;
                    else begin
                        eng_X   <= cfg_n;
                        eng_H   <= cfg_k;
                        kk_r    <= 11'(k_sq);
                        nn_r    <= 11'(n_sq);
                        mm_r    <= 11'(sq10(m_side));
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        busy    <= 1'b1;
                        s_ready <= 1'b1;
                        state   <= COLLECT;
                    end
                end
                COLLECT: if (s_hs) begin
                    in_cnt <= in_cnt + 11'd1;
                    if (in_cnt == kk_r + nn_r - 11'd1) begin
                        s_ready    <= 1'b0;
                        eng_load_h <= 1'b1;
                        ld_cnt     <= '0;
                        state      <= KPULSE;
                    end
                end
                KPULSE, KLOAD: if (ld_cnt == kk_r) begin
                    eng_load_x <= 1'b1;
                    ld_cnt     <= '0;
                    state      <= XPULSE;
                end else begin
                    eng_data_in <= kbuf[ld_cnt[KAW-1:0]];
                    ld_cnt      <= ld_cnt + 11'd1;
                    state       <= KLOAD;
                end
                XPULSE, XLOAD: if (ld_cnt == nn_r) begin
                    state <= START;
                end else begin
                    eng_data_in <= ibuf[ld_cnt[IAW-1:0]];
                    ld_cnt      <= ld_cnt + 11'd1;
                    state       <= XLOAD;
                end
                START: begin
                    eng_start <= 1'b1;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: if (eng_done) begin
                    lat_cnt <= LAT0;
                    cap_cnt <= '0;
                    state   <= CAPTURE;
                end
                CAPTURE: if (lat_cnt != '0) lat_cnt <= lat_cnt - 4'd1;
                else begin
                    cap_cnt <= cap_cnt + 11'd1;
                    if (cap_cnt == mm_r - 11'd1) state <= DRAIN;
                end
                DRAIN: if (m_hs && m_last) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_HOST_PERF_EN
    // WAIT_DONE spans exactly the eng_start cycle through the eng_done cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) perf_cycles <= '0;
        else if (state == IDLE && job_start && !cfg_bad) perf_cycles <= '0;
        else if (state == WAIT_DONE && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
    end
`endif

    conv_host_fifo #(.W(DW_OUT), .DEPTH(IMG_DEPTH)) u_res_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fifo_wr),
        .wr_data (eng_data_out),
        .rd_en   (m_hs),
        .rd_data (fifo_q),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_conv_host_if.sv
// Scoreboard bench for conv_host_if with a behavioural convolution engine model.
module tb_conv_host_if;
    localparam int RD_LAT = 2;

    logic        clk = 0, reset_n = 0, job_start = 0;
    logic [9:0]  cfg_n = 0;
    logic [2:0]  cfg_k = 0;
    logic        busy, job_err, s_valid = 0, s_ready;
    logic [7:0]  s_data = 0;
    logic        m_valid, m_ready = 0, m_last;
    logic [15:0] m_data;
    logic [9:0]  eng_X;
    logic [2:0]  eng_H;
    logic        eng_load_h, eng_load_x, eng_start, eng_reset;
    logic [7:0]  eng_data_in;
    logic        eng_done = 0;
    logic [15:0] eng_data_out = 0;
`ifdef CONV_HOST_PERF_EN
    logic [31:0] perf_cycles;
    int          exp_perf = 0;
`endif

    always #5 clk = ~clk;

    conv_host_if #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .job_start(job_start), .cfg_n(cfg_n), .cfg_k(cfg_k),
        .busy(busy), .job_err(job_err), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .eng_X(eng_X), .eng_H(eng_H), .eng_load_h(eng_load_h), .eng_load_x(eng_load_x),
        .eng_start(eng_start), .eng_data_in(eng_data_in), .eng_done(eng_done),
        .eng_data_out(eng_data_out), .eng_reset(eng_reset)
`ifdef CONV_HOST_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    int nvec = 0, nerr = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // 2D valid correlation, row-major: r[i][j] = sum h[a][b]*x[i+a][j+b]
    function automatic void conv(input int n, input int k, input int h[$], input int x[$], output int r[$]);
        int m, s;
        r = {};
        m = n - k + 1;
        for (int i = 0; i < m; i++)
            for (int j = 0; j < m; j++) begin
                s = 0;
                for (int a = 0; a < k; a++)
                    for (int b = 0; b < k; b++)
                        s += h[a*k+b] * x[(i+a)*n + j + b];
                r.push_back(s);
            end
    endfunction

    function automatic bit qeq8(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (8'(a[i]) != 8'(b[i])) return 0;
        return 1;
    endfunction

    // ---------------- engine model ----------------
    int lh_cnt = 0, lx_cnt = 0, st_cnt = 0, jerr_cnt = 0;
    int e_mode = 0, e_len = 0;
    int eh[$], ex[$];
    always @(negedge clk) begin
        if (eng_reset) e_mode = 0;
        else begin
            if (e_mode == 1) begin
                eh.push_back(int'($signed(eng_data_in)));
                if (eh.size() == e_len) e_mode = 0;
            end else if (e_mode == 2) begin
                ex.push_back(int'($signed(eng_data_in)));
                if (ex.size() == e_len) e_mode = 0;
            end
            if (eng_load_h) begin lh_cnt++; e_mode = 1; eh.delete(); e_len = int'(eng_H) * int'(eng_H); end
            if (eng_load_x) begin lx_cnt++; e_mode = 2; ex.delete(); e_len = int'(eng_X) * int'(eng_X); end
            if (eng_start) st_cnt++;
        end
        if (job_err) jerr_cnt++;
    end

    int eres[$];
    int dly;
    initial begin
        forever begin
            @(negedge clk);
            if (eng_start && !eng_reset) begin
                conv(int'(eng_X), int'(eng_H), eh, ex, eres);
                dly = $urandom_range(1, 6);
`ifdef CONV_HOST_PERF_EN
                exp_perf = dly + 1;
`endif
                repeat (dly) @(posedge clk);
                #1 eng_done = 1;
                @(posedge clk);
                #1 eng_done = 0;
                repeat (RD_LAT - 1) @(posedge clk);
                #1;
                foreach (eres[w]) begin
                    eng_data_out = 16'(eres[w]);
                    @(posedge clk);
                    #1;
                end
                eng_data_out = 16'hBEEF;
            end
        end
    end

    // ---------------- consumer + scoreboard ----------------
    typedef struct { logic [15:0] d; logic l; } exp_t;
    exp_t sbq[$];
    int   rdy_mode = 0;

    always @(posedge clk) begin
        #1 m_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    end

    logic        prev_stall = 0;
    logic [15:0] prev_d = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) prev_stall = 0;
        else begin
            if (prev_stall) chk("hold_while_stalled", {m_valid, m_data}, {1'b1, prev_d});
            if (m_valid && m_ready) begin
                if (sbq.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL unexpected_result: got %0h expected no output", m_data);
                end else begin
                    e = sbq.pop_front();
                    chk("m_data", m_data, e.d);
                    chk("m_last", m_last, e.l);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
        end
    end

    // ---------------- stimulus ----------------
    int gk[$], gi[$], gexp[$];

    task automatic check_reset_outs();
        chk("rst_ctrl", {busy, job_err, s_ready, m_valid, m_last, eng_load_h, eng_load_x, eng_start}, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_eng_cfg", {eng_X, eng_H}, 0);
        chk("rst_eng_din", eng_data_in, 0);
        chk("rst_eng_reset", eng_reset, 1);
    endtask

    task automatic start_and_feed(input int n, input int k, input int vmode);
        int total, idx, guard;
        bit hs, tog;
        @(posedge clk);
        #1 cfg_n = 10'(n); cfg_k = 3'(k); job_start = 1;
        @(posedge clk);
        #1 job_start = 0;
        chk("busy_set", busy, 1);
        total = k*k + n*n; idx = 0; guard = 0; tog = 0;
        while (idx < total && guard < 8000) begin
            tog     = !tog;
            s_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom_range(0, 1));
            s_data  = 8'(idx < k*k ? gk[idx] : gi[idx - k*k]);
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (hs) idx++;
            guard++;
        end
        s_valid = 0;
        chk("collect_words", idx, total);
    endtask

    task automatic run_job(input int n, input int k, input int vmode);
        int r[$];
        int blh, blx, bst, guard;
        exp_t e;
        blh = lh_cnt; blx = lx_cnt; bst = st_cnt;
        if (gexp.size() == 0) conv(n, k, gk, gi, r);
        else r = gexp;
        foreach (r[i]) begin
            e.d = 16'(r[i]);
            e.l = (i == r.size() - 1);
            sbq.push_back(e);
        end
        start_and_feed(n, k, vmode);
        guard = 0;
        while ((busy || sbq.size() != 0) && guard < 8000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("job_complete", guard < 8000, 1);
        chk("load_h_cycles", lh_cnt - blh, 1);
        chk("load_x_cycles", lx_cnt - blx, 1);
        chk("start_cycles", st_cnt - bst, 1);
        chk("kernel_burst", qeq8(eh, gk), 1);
        chk("image_burst", qeq8(ex, gi), 1);
        chk("eng_X", eng_X, n);
        chk("eng_H", eng_H, k);
        sbq.delete();
    endtask

    task automatic job_a(input int vmode);
        int lit[9] = '{7, 9, 11, 15, 17, 19, 23, 25, 27};
        gk.delete(); gi.delete(); gexp.delete();
        gk.push_back(1); gk.push_back(0); gk.push_back(0); gk.push_back(1);
        for (int i = 1; i <= 16; i++) gi.push_back(i);
        foreach (lit[i]) gexp.push_back(lit[i]);
        run_job(4, 2, vmode);
    endtask

    initial begin
        int bj, g, n, k;
        repeat (3) @(posedge clk);
        #1 check_reset_outs();
        reset_n = 1;
        #1 chk("eng_reset_hold", eng_reset, 1);
        @(posedge clk);
        #1 chk("eng_reset_release", eng_reset, 0);

        job_a(0);
        job_a(1);
        rdy_mode = 1;
        job_a(0);
        rdy_mode = 0;

        // rejected configuration
        bj = jerr_cnt;
        @(posedge clk);
        #1 cfg_n = 10'd3; cfg_k = 3'd4; job_start = 1;
        @(posedge clk);
        #1 job_start = 0;
        chk("job_err_pulse", job_err, 1);
        chk("busy_rejected", busy, 0);
        chk("s_ready_rejected", s_ready, 0);
        repeat (3) @(posedge clk);
        #1 chk("job_err_count", jerr_cnt - bj, 1);
        chk("busy_after_reject", busy, 0);
        chk("s_ready_after_reject", s_ready, 0);

        // abort during KLOAD
        start_and_feed(4, 2, 0);
        g = 0;
        while (!eng_load_h && g < 200) begin @(negedge clk); g++; end
        chk("reach_kload", g < 200, 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 0;
        #1 check_reset_outs();
        @(posedge clk);
        #1 reset_n = 1;
        #1 chk("eng_reset_hold2", eng_reset, 1);
        @(posedge clk);
        #1 chk("eng_reset_release2", eng_reset, 0);
        chk("busy_after_abort", busy, 0);
        job_a(0);

        // K = N, single result
        gk.delete(); gi.delete(); gexp.delete();
        for (int i = 0; i < 9; i++) begin gk.push_back(1); gi.push_back(1); end
        gexp.push_back(9);
        run_job(3, 3, 0);
`ifdef CONV_HOST_PERF_EN
        chk("perf_nonzero", perf_cycles != 0, 1);
        chk("perf_cycles", perf_cycles, exp_perf);
`endif

        // randomized jobs with random valid and ready
        rdy_mode = 1;
        for (int t = 0; t < 5; t++) begin
            n = $urandom_range(2, 8);
            k = $urandom_range(1, (n < 5) ? n : 5);
            gk.delete(); gi.delete(); gexp.delete();
            for (int i = 0; i < k*k; i++) gk.push_back(int'($urandom_range(0, 255)) - 128);
            for (int i = 0; i < n*n; i++) gi.push_back(int'($urandom_range(0, 255)) - 128);
            run_job(n, k, 2);
        end
        rdy_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected summary first");
        $fatal(1);
    end

endmodule
